floo_serial_link_vc_mux: RTL and testbench

- Credit-based virtual-channel multiplexer for the serial link network layer.
- Merges NumVc independent flit streams onto one physical link, for example narrow request, narrow response and wide.
- Each VC has its own credit counter, replenished by credit returns from the remote side.
- Arbitration is round-robin, with an optional per-VC strict-priority override. The block sits between the NoC flit interfaces and the data-link layer.

---
 rtl/floo_serial_link_vc_mux.sv | 149 ++++++++++++++
 tb/tb_floo_serial_link_vc_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_serial_link_vc_mux.sv
// Credit-based VC multiplexer: merges NumVc flit streams onto one link, with round-robin and strict-priority arbitration.
// Latency: 1 cycle from vc_valid_i to link_valid_o through a single output register; full throughput.
// Backpressure: vc_ready_o drops while the output register is full and link_ready_i is low, or while a VC has no credits.
module floo_serial_link_vc_mux #(
    parameter int unsigned NumVc      = 3,
    parameter int unsigned FlitWidth  = 64,
    parameter int unsigned NumCredits = 8,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1),
    parameter int unsigned VcIdWidth  = (NumVc > 1) ? $clog2(NumVc) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumVc-1:0]              vc_valid_i,
    output logic [NumVc-1:0]              vc_ready_o,
    input  logic [NumVc*FlitWidth-1:0]    vc_data_i,
    output logic                          link_valid_o,
    input  logic                          link_ready_i,
    output logic [FlitWidth-1:0]          link_data_o,
    output logic [VcIdWidth-1:0]          link_vc_o,
    input  logic                          credit_valid_i,
    input  logic [VcIdWidth-1:0]          credit_vc_i,
    input  logic [NumVc-1:0]              prio_i,
    input  logic                          credit_clear_i,
    output logic [NumVc*CntWidth-1:0]     credits_o,
    output logic                          credit_err_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumCredits);

    logic [CntWidth-1:0]  credit_q [NumVc];
    logic [VcIdWidth-1:0] rr_ptr_q;
    logic [NumVc-1:0]     eligible;
    logic [NumVc-1:0]     ret_hit;
    logic [NumVc-1:0]     credit_ovf;
    logic [VcIdWidth-1:0] grant_idx;
    logic [FlitWidth-1:0] grant_data;
    logic                 grant_vld;
    logic                 grant_prio;
    logic                 load;
    logic                 vc_illegal;

    always_comb begin
        for (int i = 0; i < int'(NumVc); i++) begin
            eligible[i] = vc_valid_i[i] && (credit_q[i] != '0);
        end
    end

    // Descending loops leave the lowest index / smallest pointer offset as the winner.
    always_comb begin
        int idx;
        idx        = 0;
        grant_vld  = 1'b0;
        grant_prio = 1'b0;
        grant_idx  = '0;
        for (int i = int'(NumVc) - 1; i >= 0; i--) begin
            if (eligible[i] && prio_i[i]) begin
                grant_vld  = 1'b1;
                grant_prio = 1'b1;
                grant_idx  = VcIdWidth'(i);
            end
        end
        if (!grant_prio) begin
            for (int k = int'(NumVc) - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + k) % int'(NumVc);
                if (eligible[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = VcIdWidth'(idx);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NumVc); i++) begin
            if (int'(grant_idx) == i) begin
                grant_data = vc_data_i[i*FlitWidth +: FlitWidth];
            end
        end
    end

    assign load = !link_valid_o || link_ready_i;

    always_comb begin
        vc_ready_o = '0;
        for (int i = 0; i < int'(NumVc); i++) begin
            vc_ready_o[i] = load && grant_vld && (int'(grant_idx) == i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            link_valid_o <= 1'b0;
            link_data_o  <= '0;
            link_vc_o    <= '0;
            rr_ptr_q     <= '0;
        end else if (load) begin
            link_valid_o <= grant_vld;
            if (grant_vld) begin
                link_data_o <= grant_data;
                link_vc_o   <= grant_idx;
                if (!grant_prio) begin
                    rr_ptr_q <= (int'(grant_idx) == int'(NumVc) - 1) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    // A return and a consume on the same VC cancel out, so only a lone return can overflow.
    always_comb begin
        for (int i = 0; i < int'(NumVc); i++) begin
            ret_hit[i]    = credit_valid_i && (int'(credit_vc_i) == i);
            credit_ovf[i] = ret_hit[i] && !vc_ready_o[i] && (credit_q[i] == CntMax);
        end
        vc_illegal = credit_valid_i && (int'(credit_vc_i) >= int'(NumVc));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumVc); i++) begin
                credit_q[i] <= CntMax;
            end
            credit_err_o <= 1'b0;
        end else if (credit_clear_i) begin
            for (int i = 0; i < int'(NumVc); i++) begin
                credit_q[i] <= CntMax;
            end
            credit_err_o <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NumVc); i++) begin
                if (vc_ready_o[i] && !ret_hit[i]) begin
                    credit_q[i] <= credit_q[i] - 1'b1;
                end else if (ret_hit[i] && !vc_ready_o[i] && !credit_ovf[i]) begin
                    credit_q[i] <= credit_q[i] + 1'b1;
                end
            end
            if ((|credit_ovf) || vc_illegal) begin
                credit_err_o <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NumVc); i++) begin
            credits_o[i*CntWidth +: CntWidth] = credit_q[i];
        end
    end

endmodule

// File: tb/tb_floo_serial_link_vc_mux.sv
// Bench for floo_serial_link_vc_mux: directed corner sequences, a credit-rule vector table, then random traffic against a queue-free cycle model.
module tb_floo_serial_link_vc_mux;
    localparam int NV = 3;
    localparam int FW = 64;
    localparam int NC = 8;
    localparam int CW = 4;
    localparam int VW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NV-1:0]      vvalid;
    logic [NV-1:0]      vready;
    logic [NV*FW-1:0]   vdata;
    logic [FW-1:0]      vdat [NV];
    logic               lvalid;
    logic               lrdy;
    logic [FW-1:0]      ldata;
    logic [VW-1:0]      lvc;
    logic               cv;
    logic [VW-1:0]      cvc;
    logic [NV-1:0]      prio;
    logic               clr;
    logic [NV*CW-1:0]   credits;
    logic               cerr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NV; i++) vdata[i*FW +: FW] = vdat[i];
    end

    floo_serial_link_vc_mux #(.NumVc(NV), .FlitWidth(FW), .NumCredits(NC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .vc_valid_i(vvalid), .vc_ready_o(vready), .vc_data_i(vdata),
        .link_valid_o(lvalid), .link_ready_i(lrdy), .link_data_o(ldata), .link_vc_o(lvc),
        .credit_valid_i(cv), .credit_vc_i(cvc), .prio_i(prio), .credit_clear_i(clr),
        .credits_o(credits), .credit_err_o(cerr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cred_of(input int i);
        return 64'(credits[i*CW +: CW]);
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_credits();
        clr = 1'b1;
        @(negedge clk);
        next();
        clr = 1'b0;
    endtask

    typedef struct {
        logic [2:0] v;
        logic       cv;
        logic [1:0] cvc;
        logic       clr;
        logic [2:0] rdy;
        int         c0, c1, c2;
        logic       err;
    } vec_t;
    vec_t tbl [15];

    // Reference model state for the random phase
    int         m_cred [NV];
    int         m_ptr;
    bit         m_ovld;
    logic [63:0] m_odata;
    int         m_ovc;
    bit         m_err;

    initial begin
        tbl[0]  = '{3'b001, 1'b1, 2'd0, 1'b0, 3'b001, 8, 8, 8, 1'b0};
        tbl[1]  = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b0};
        tbl[2]  = '{3'b000, 1'b1, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b0};
        tbl[3]  = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b1};
        tbl[4]  = '{3'b000, 1'b0, 2'd0, 1'b1, 3'b000, 8, 8, 8, 1'b1};
        tbl[5]  = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b0};
        tbl[6]  = '{3'b000, 1'b1, 2'd3, 1'b0, 3'b000, 8, 8, 8, 1'b0};
        tbl[7]  = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b1};
        tbl[8]  = '{3'b010, 1'b0, 2'd0, 1'b0, 3'b010, 8, 8, 8, 1'b1};
        tbl[9]  = '{3'b010, 1'b0, 2'd0, 1'b1, 3'b010, 8, 7, 8, 1'b1};
        tbl[10] = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b0};
        tbl[11] = '{3'b001, 1'b1, 2'd1, 1'b0, 3'b001, 8, 8, 8, 1'b0};
        tbl[12] = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 7, 8, 8, 1'b1};
        tbl[13] = '{3'b000, 1'b1, 2'd0, 1'b0, 3'b000, 7, 8, 8, 1'b1};
        tbl[14] = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8, 8, 8, 1'b1};

        rst_n = 1'b0; vvalid = '0; lrdy = 1'b0; cv = 1'b0; cvc = '0; prio = '0; clr = 1'b0;
        for (int i = 0; i < NV; i++) vdat[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_link_valid", 64'(lvalid), 64'd0);
        chk("rst_link_data", ldata, 64'd0);
        chk("rst_link_vc", 64'(lvc), 64'd0);
        chk("rst_err", 64'(cerr), 64'd0);
        for (int i = 0; i < NV; i++) chk($sformatf("rst_cred%0d", i), cred_of(i), 64'(NC));
        rst_n = 1'b1;
        next();

        // Round-robin until all credits are spent
        vvalid = 3'b111; lrdy = 1'b1;
        for (int n = 0; n < 27; n++) begin
            for (int i = 0; i < NV; i++) vdat[i] = 64'hD0D0_0000_0000_0000 | 64'(i*256 + n);
            @(negedge clk);
            chk($sformatf("rr_rdy[%0d]", n), 64'(vready), (n < 24) ? 64'(1 << (n % 3)) : 64'd0);
            if (n >= 1 && n <= 24) begin
                chk($sformatf("rr_lvalid[%0d]", n), 64'(lvalid), 64'd1);
                chk($sformatf("rr_lvc[%0d]", n), 64'(lvc), 64'((n-1) % 3));
                chk($sformatf("rr_ldata[%0d]", n), ldata,
                    64'hD0D0_0000_0000_0000 | 64'(((n-1) % 3)*256 + (n-1)));
            end
            if (n >= 25) chk($sformatf("rr_drain[%0d]", n), 64'(lvalid), 64'd0);
            if (n == 12) for (int i = 0; i < NV; i++) chk($sformatf("rr_cred_half%0d", i), cred_of(i), 64'd4);
            if (n == 24) for (int i = 0; i < NV; i++) chk($sformatf("rr_cred_zero%0d", i), cred_of(i), 64'd0);
            next();
        end

        // Credit return wakes a starved VC one cycle later
        vvalid = 3'b010; cv = 1'b1; cvc = 2'd1;
        @(negedge clk);
        chk("ret_rdy_T", 64'(vready), 64'd0);
        chk("ret_cred_T", cred_of(1), 64'd0);
        next();
        cv = 1'b0;
        @(negedge clk);
        chk("ret_rdy_T1", 64'(vready), 64'b010);
        chk("ret_cred_T1", cred_of(1), 64'd1);
        next();
        @(negedge clk);
        chk("ret_rdy_T2", 64'(vready), 64'd0);
        chk("ret_cred_T2", cred_of(1), 64'd0);
        vvalid = '0;
        next();
        clear_credits();
        @(negedge clk);
        for (int i = 0; i < NV; i++) chk($sformatf("clr_cred%0d", i), cred_of(i), 64'(NC));
        chk("clr_err", 64'(cerr), 64'd0);

        // Move the pointer to 1, then a priority burst must leave it there
        next();
        vvalid = 3'b001;
        @(negedge clk);
        chk("pre_prio_rdy", 64'(vready), 64'b001);
        next();
        vvalid = 3'b111; prio = 3'b100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("prio_rdy[%0d]", k), 64'(vready),
                (k < 8) ? 64'b100 : (((k - 8) % 2 == 0) ? 64'b010 : 64'b001));
            next();
        end
        vvalid = '0; prio = '0;
        next();
        clear_credits();

        // Stall holds the output stable; release drains without a bubble
        for (int i = 0; i < NV; i++) vdat[i] = 64'hCAFE_0000_0000_0000 + 64'(i);
        vvalid = 3'b111; lrdy = 1'b0;
        @(negedge clk);
        chk("stall_load_rdy", 64'(vready), 64'b010);
        next();
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            chk($sformatf("stall_rdy[%0d]", s), 64'(vready), 64'd0);
            chk($sformatf("stall_lvalid[%0d]", s), 64'(lvalid), 64'd1);
            chk($sformatf("stall_lvc[%0d]", s), 64'(lvc), 64'd1);
            chk($sformatf("stall_ldata[%0d]", s), ldata, 64'hCAFE_0000_0000_0001);
            next();
        end
        lrdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            chk($sformatf("rel_rdy[%0d]", r), 64'(vready), 64'(1 << ((r + 2) % 3)));
            chk($sformatf("rel_lvalid[%0d]", r), 64'(lvalid), 64'd1);
            chk($sformatf("rel_lvc[%0d]", r), 64'(lvc), 64'((r + 1) % 3));
            chk($sformatf("rel_ldata[%0d]", r), ldata, 64'hCAFE_0000_0000_0000 + 64'((r + 1) % 3));
            next();
        end
        vvalid = '0;
        next();
        next();
        clear_credits();

        // Credit accounting rules, one vector per cycle
        for (int t = 0; t < 15; t++) begin
            vvalid = tbl[t].v; cv = tbl[t].cv; cvc = tbl[t].cvc; clr = tbl[t].clr;
            @(negedge clk);
            chk($sformatf("tbl_rdy[%0d]", t), 64'(vready), 64'(tbl[t].rdy));
            chk($sformatf("tbl_cred[%0d]", t), 64'(credits), 64'({tbl[t].c2[3:0], tbl[t].c1[3:0], tbl[t].c0[3:0]}));
            chk($sformatf("tbl_err[%0d]", t), 64'(cerr), 64'(tbl[t].err));
            next();
        end
        vvalid = '0; cv = 1'b0; cvc = '0; clr = 1'b0;

        // Asynchronous reset while stalled
        clear_credits();
        vvalid = 3'b001; lrdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            next();
        end
        vvalid = '0; lrdy = 1'b0;
        @(negedge clk);
        chk("arst_pre_lvalid", 64'(lvalid), 64'd1);
        chk("arst_pre_cred0", cred_of(0), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_lvalid", 64'(lvalid), 64'd0);
        chk("arst_ldata", ldata, 64'd0);
        chk("arst_lvc", 64'(lvc), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next();
        @(negedge clk);
        for (int i = 0; i < NV; i++) chk($sformatf("arst_cred%0d", i), cred_of(i), 64'(NC));
        chk("arst_err", 64'(cerr), 64'd0);
        next();

        // Random traffic against the reference model
        for (int i = 0; i < NV; i++) m_cred[i] = NC;
        m_ptr = 0; m_ovld = 0; m_odata = '0; m_ovc = 0; m_err = 0;
        for (int c = 0; c < 2000; c++) begin
            int g, r;
            bit is_prio, load;
            logic [NV-1:0] exp_rdy;
            vvalid = NV'($urandom);
            lrdy = ($urandom % 10) < 7;
            if (c % 150 == 0) prio = ($urandom % 3 == 0) ? NV'($urandom) : '0;
            r = int'($urandom % 100);
            if (r < 55) begin cv = 1'b1; cvc = VW'($urandom % 3); end
            else if (r < 57) begin cv = 1'b1; cvc = 2'd3; end
            else begin cv = 1'b0; cvc = VW'($urandom); end
            clr = ($urandom % 100) == 0;
            for (int i = 0; i < NV; i++) vdat[i] = {$urandom, $urandom};

            g = -1; is_prio = 0;
            for (int i = 0; i < NV; i++)
                if (g < 0 && vvalid[i] && m_cred[i] > 0 && prio[i]) begin g = i; is_prio = 1; end
            for (int k = 0; k < NV; k++)
                if (g < 0 && vvalid[(m_ptr + k) % NV] && m_cred[(m_ptr + k) % NV] > 0) g = (m_ptr + k) % NV;
            load = !m_ovld || lrdy;
            exp_rdy = (load && g >= 0) ? NV'(1 << g) : '0;

            @(negedge clk);
            chk($sformatf("rnd_rdy[%0d]", c), 64'(vready), 64'(exp_rdy));
            chk($sformatf("rnd_lvalid[%0d]", c), 64'(lvalid), 64'(m_ovld));
            if (m_ovld) begin
                chk($sformatf("rnd_lvc[%0d]", c), 64'(lvc), 64'(m_ovc));
                chk($sformatf("rnd_ldata[%0d]", c), ldata, m_odata);
            end
            for (int i = 0; i < NV; i++) chk($sformatf("rnd_cred%0d[%0d]", i, c), cred_of(i), 64'(m_cred[i]));
            chk($sformatf("rnd_err[%0d]", c), 64'(cerr), 64'(m_err));

            if (load) begin
                m_ovld = (g >= 0);
                if (g >= 0) begin
                    m_odata = vdat[g];
                    m_ovc = g;
                    if (!is_prio) m_ptr = (g + 1) % NV;
                end
            end
            if (clr) begin
                for (int i = 0; i < NV; i++) m_cred[i] = NC;
                m_err = 0;
            end else begin
                for (int i = 0; i < NV; i++) begin
                    bit cons, ret;
                    cons = exp_rdy[i];
                    ret = cv && (int'(cvc) == i);
                    if (cons && !ret) m_cred[i]--;
                    else if (ret && !cons) begin
                        if (m_cred[i] == NC) m_err = 1;
                        else m_cred[i]++;
                    end
                end
                if (cv && int'(cvc) >= NV) m_err = 1;
            end
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
